matrix_scan_ctrl: RTL

- Row-scan sequencer for the 8x8 LED matrix in the pong display.
- Drives the row index `count` into the game renderer and captures the row pattern it returns.
- Serialises that pattern into the external column shift register, then latches it and enables the matching row driver for a fixed dwell time.
- Cycles rows 0..WIDTH-1 continuously while enabled, pulsing `frame_done` once per full frame.

---
 rtl/matrix_scan_ctrl_if.sv | 36 +++
 rtl/matrix_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if
// Bundles the renderer handshake and the column shift-register / row-driver
// signals of the LED matrix row-scan sequencer.
//   master : the scan controller (drives count and all display outputs)
//   slave  : the environment (renderer + enable source)
// Signals:
//   enable     scan run request
//   row_data   renderer row pattern, [WIDTH-1:0] used
//   count      row index presented to the renderer
//   sdata      serial column data
//   sclk       shift clock, idles low
//   latch      one-cycle strobe to the shift-register output latch
//   row_sel    one-hot active-high row enable
//   frame_done one-cycle pulse after the last row's dwell
interface matrix_scan_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [15:0]      row_data;
  logic [2:0]       count;
  logic             sdata;
  logic             sclk;
  logic             latch;
  logic [WIDTH-1:0] row_sel;
  logic             frame_done;

  modport master (
    input  enable, row_data,
    output count, sdata, sclk, latch, row_sel, frame_done
  );

  modport slave (
    output enable, row_data,
    input  count, sdata, sclk, latch, row_sel, frame_done
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl
// Row-scan sequencer for the 8x8 pong LED matrix. For each row it presents
// the row index to the renderer, captures the returned pattern, shifts it out
// MSB first to the column shift register, latches it and lights the row for
// DWELL cycles. Rows cycle continuously while enable is high.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  matrix_scan_ctrl_if.master (enable, row_data in; count, sdata,
//        sclk, latch, row_sel, frame_done out)
// Parameters: WIDTH (2..8 rows/cols), DWELL (>=1), SHIFT_DIV (>=1).
// Build option: define MATRIX_SCAN_BLANK_EN to blank row_sel during FETCH and
// SHIFT; otherwise the previous row stays lit until the next LATCH.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | outputs at reset values, waiting for enable
// FETCH   | 2 cycles, count stable, row_data captured at end of 2nd
// SHIFT   | WIDTH bits out, each SHIFT_DIV low + SHIFT_DIV high cycles
// LATCH   | 1 cycle, latch strobe and row_sel = one-hot(count)
// DISPLAY | DWELL cycles, row held; last cycle advances count
module matrix_scan_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DWELL     = 1000,
  parameter int SHIFT_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  matrix_scan_ctrl_if.master bus
);

  localparam int DIV_W   = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DIV_W-1:0]   DIV_RELOAD   = DIV_W'(SHIFT_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL - 1);
  localparam logic [2:0]         LAST_ROW     = 3'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ROW_ONE      = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t             r_state;
  logic [2:0]         r_count;
  logic               r_sdata;
  logic               r_sclk;
  logic               r_latch;
  logic [WIDTH-1:0]   r_row_sel;
  logic               r_frame_done;
  logic               r_fetch_cnt;
  logic [WIDTH-1:0]   r_shreg;
  logic [2:0]         r_bit;
  logic [DIV_W-1:0]   r_div;
  logic [DWELL_W-1:0] r_dwell;

  logic [WIDTH-1:0]   w_onehot;
  logic               w_unused;

  assign w_onehot = ROW_ONE << r_count;
  // Upper renderer bits are unused by design.
  assign w_unused = ^bus.row_data[15:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_sdata      <= 1'b0;
      r_sclk       <= 1'b0;
      r_latch      <= 1'b0;
      r_row_sel    <= '0;
      r_frame_done <= 1'b0;
      r_fetch_cnt  <= 1'b0;
      r_shreg      <= '0;
      r_bit        <= '0;
      r_div        <= '0;
      r_dwell      <= '0;
    end else begin
      r_latch      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_state     <= S_FETCH;
            r_count     <= '0;
            r_fetch_cnt <= 1'b0;
          end
        end

        S_FETCH: begin
          if (!r_fetch_cnt) begin
            r_fetch_cnt <= 1'b1;
          end else begin
            // MSB goes out on the same edge the pattern is captured.
            r_shreg <= bus.row_data[WIDTH-1:0];
            r_sdata <= bus.row_data[WIDTH-1];
            r_sclk  <= 1'b0;
            r_div   <= DIV_RELOAD;
            r_bit   <= LAST_ROW;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - DIV_W'(1);
          end else if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_div  <= DIV_RELOAD;
          end else if (r_bit == '0) begin
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_latch   <= 1'b1;
            r_row_sel <= w_onehot;
            r_state   <= S_LATCH;
          end else begin
            r_sclk  <= 1'b0;
            r_div   <= DIV_RELOAD;
            r_bit   <= r_bit - 3'd1;
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_sdata <= r_shreg[WIDTH-2];
          end
        end

        S_LATCH: begin
          r_dwell <= DWELL_RELOAD;
          r_state <= S_DISPLAY;
        end

        S_DISPLAY: begin
          if (r_dwell != '0) begin
            r_dwell <= r_dwell - DWELL_W'(1);
          end else begin
            if (r_count == LAST_ROW) begin
              r_count      <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_count <= r_count + 3'd1;
            end
            if (bus.enable) begin
              r_state     <= S_FETCH;
              r_fetch_cnt <= 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
              r_row_sel   <= '0;
`endif
            end else begin
              r_state   <= S_IDLE;
              r_row_sel <= '0;
              r_count   <= '0;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.count      = r_count;
  assign bus.sdata      = r_sdata;
  assign bus.sclk       = r_sclk;
  assign bus.latch      = r_latch;
  assign bus.row_sel    = r_row_sel;
  assign bus.frame_done = r_frame_done;

endmodule
